// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one D$ request port between the store queue head and the load queue.
// One request is in flight at a time: IDLE grants, ISSUE presents the latched
// request to the D$, WAIT_RESP (loads only) waits for the returned data.
//
// Handshake semantics (all valid/ready pairs in this block):
//   A transfer happens in a cycle where valid and ready are both high. Once
//   valid is raised, valid and every payload field stay constant until that
//   transfer. Here the "ready" toward the queues is the combinational
//   sq_req_accept / lq_req_accept pulse, and dc_req_ready is the D$ side ready.
//
// Command encoding on dc_req_cmd: 0 = no request, 1 = MEM_LOAD, 2 = MEM_STORE.
module mem_port_arbiter #(
  parameter int SQ_SIZE      = 128,
  parameter int SQ_LOW_WATER = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int LQ_TAG_W     = 4,
  parameter int ADDR_W       = 32,
  parameter int SIZE_W       = 2,
  parameter int DATA_W       = 64,
  localparam int FREE_W      = $clog2(SQ_SIZE + 1),
  localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  // store queue side
  input  logic                sq_req_valid,
  input  logic [ADDR_W-1:0]   sq_req_addr,
  input  logic [SIZE_W-1:0]   sq_req_size,
  input  logic [DATA_W-1:0]   sq_store_data,
  input  logic [FREE_W-1:0]   sq_free_num_slot,
  output logic                sq_req_accept,
  // load queue side
  input  logic                lq_req_valid,
  input  logic [ADDR_W-1:0]   lq_req_addr,
  input  logic [SIZE_W-1:0]   lq_req_size,
  input  logic [LQ_TAG_W-1:0] lq_req_tag,
  output logic                lq_req_accept,
  // D$ request
  output logic                dc_req_valid,
  output logic [ADDR_W-1:0]   dc_req_addr,
  output logic [SIZE_W-1:0]   dc_req_size,
  output logic [1:0]          dc_req_cmd,
  output logic [DATA_W-1:0]   dc_req_data,
  input  logic                dc_req_ready,
  // D$ response and load completion
  input  logic                dc_resp_valid,
  input  logic [DATA_W-1:0]   dc_resp_data,
  output logic                lq_resp_valid,
  output logic [DATA_W-1:0]   lq_resp_data,
  output logic [LQ_TAG_W-1:0] lq_resp_tag,
  // control and status
  input  logic                flush_i,
  output logic                busy_o,
  // debug visibility of the FSM and fairness counter
  output logic [1:0]          dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [FREE_W-1:0]   LOW_WATER  = FREE_W'(SQ_LOW_WATER);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t                state;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  kill;
  logic                  lat_is_store;
  logic [LQ_TAG_W-1:0]   lat_tag;

  // The dc_* registers double as the latched request: loaded at grant,
  // cleared at the D$ handshake, so they read zero whenever not in ISSUE.
  logic                  dc_valid_q;
  logic [ADDR_W-1:0]     dc_addr_q;
  logic [SIZE_W-1:0]     dc_size_q;
  logic [1:0]            dc_cmd_q;
  logic [DATA_W-1:0]     dc_data_q;

  logic                  resp_valid_q;
  logic [DATA_W-1:0]     resp_data_q;
  logic [LQ_TAG_W-1:0]   resp_tag_q;

  logic                  store_pri;
  logic                  grant_store;
  logic                  grant_load;

  // Arbitration: the store wins when it is alone, when loads are being
  // squashed, when the SQ is nearly full, or when loads have starved it.
  always_comb begin
    store_pri   = 1'b0;
    grant_store = 1'b0;
    grant_load  = 1'b0;
    store_pri   = !lq_req_valid || flush_i ||
                  (sq_free_num_slot <= LOW_WATER) ||
                  (starve_cnt >= STARVE_MAX);
    if ((state == IDLE) && !reset) begin
      grant_store = sq_req_valid && store_pri;
      grant_load  = lq_req_valid && !flush_i && !grant_store;
    end
  end

  // Control FSM with latched request, fairness counter, kill flag and the
  // registered load completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      kill         <= 1'b0;
      lat_is_store <= 1'b0;
      lat_tag      <= '0;
      dc_valid_q   <= 1'b0;
      dc_addr_q    <= '0;
      dc_size_q    <= '0;
      dc_cmd_q     <= MEM_NONE;
      dc_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      // completion is a single-cycle pulse
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_store) begin
            starve_cnt   <= '0;
            lat_is_store <= 1'b1;
            lat_tag      <= '0;
            dc_valid_q   <= 1'b1;
            dc_addr_q    <= sq_req_addr;
            dc_size_q    <= sq_req_size;
            dc_cmd_q     <= MEM_STORE;
            dc_data_q    <= sq_store_data;
            state        <= ISSUE;
          end else if (grant_load) begin
            // only count loads that actually made a store wait
            if (sq_req_valid && (starve_cnt < STARVE_MAX)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            lat_is_store <= 1'b0;
            lat_tag      <= lq_req_tag;
            dc_valid_q   <= 1'b1;
            dc_addr_q    <= lq_req_addr;
            dc_size_q    <= lq_req_size;
            dc_cmd_q     <= MEM_LOAD;
            dc_data_q    <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // a squashed load still finishes its D$ transaction, silently
          if (flush_i && !lat_is_store) begin
            kill <= 1'b1;
          end
          if (dc_req_ready) begin
            dc_valid_q <= 1'b0;
            dc_addr_q  <= '0;
            dc_size_q  <= '0;
            dc_cmd_q   <= MEM_NONE;
            dc_data_q  <= '0;
            if (lat_is_store) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (flush_i) begin
            kill <= 1'b1;
          end
          if (dc_resp_valid) begin
            // a flush arriving with the data also suppresses it
            if (!kill && !flush_i) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= dc_resp_data;
              resp_tag_q   <= lat_tag;
            end
            kill  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs: accepts are combinational; everything else comes from
  // registers and is forced to zero while reset is held.
  assign sq_req_accept  = grant_store;
  assign lq_req_accept  = grant_load;

  assign dc_req_valid   = dc_valid_q && !reset;
  assign dc_req_addr    = reset ? '0 : dc_addr_q;
  assign dc_req_size    = reset ? '0 : dc_size_q;
  assign dc_req_cmd     = reset ? MEM_NONE : dc_cmd_q;
  assign dc_req_data    = reset ? '0 : dc_data_q;

  assign lq_resp_valid  = resp_valid_q && !reset;
  assign lq_resp_data   = reset ? '0 : resp_data_q;
  assign lq_resp_tag    = reset ? '0 : resp_tag_q;

  assign busy_o         = (state != IDLE) && !reset;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed vectors for the arbitration rules, hand-written sequences for the
// multi-cycle cases, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int SQ_SIZE      = 128;
  localparam int SQ_LOW_WATER = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int LQ_TAG_W     = 4;
  localparam int ADDR_W       = 32;
  localparam int SIZE_W       = 2;
  localparam int DATA_W       = 64;
  localparam int FREE_W       = $clog2(SQ_SIZE + 1);
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic                sq_req_valid;
  logic [ADDR_W-1:0]   sq_req_addr;
  logic [SIZE_W-1:0]   sq_req_size;
  logic [DATA_W-1:0]   sq_store_data;
  logic [FREE_W-1:0]   sq_free_num_slot;
  logic                sq_req_accept;
  logic                lq_req_valid;
  logic [ADDR_W-1:0]   lq_req_addr;
  logic [SIZE_W-1:0]   lq_req_size;
  logic [LQ_TAG_W-1:0] lq_req_tag;
  logic                lq_req_accept;
  logic                dc_req_valid;
  logic [ADDR_W-1:0]   dc_req_addr;
  logic [SIZE_W-1:0]   dc_req_size;
  logic [1:0]          dc_req_cmd;
  logic [DATA_W-1:0]   dc_req_data;
  logic                dc_req_ready;
  logic                dc_resp_valid;
  logic [DATA_W-1:0]   dc_resp_data;
  logic                lq_resp_valid;
  logic [DATA_W-1:0]   lq_resp_data;
  logic [LQ_TAG_W-1:0] lq_resp_tag;
  logic                flush_i;
  logic                busy_o;
  logic [1:0]          dbg_state;
  logic [STARVE_W-1:0] dbg_starve_cnt;

  mem_port_arbiter #(
    .SQ_SIZE(SQ_SIZE), .SQ_LOW_WATER(SQ_LOW_WATER), .STARVE_LIMIT(STARVE_LIMIT),
    .LQ_TAG_W(LQ_TAG_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .sq_req_valid(sq_req_valid), .sq_req_addr(sq_req_addr), .sq_req_size(sq_req_size),
    .sq_store_data(sq_store_data), .sq_free_num_slot(sq_free_num_slot),
    .sq_req_accept(sq_req_accept),
    .lq_req_valid(lq_req_valid), .lq_req_addr(lq_req_addr), .lq_req_size(lq_req_size),
    .lq_req_tag(lq_req_tag), .lq_req_accept(lq_req_accept),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_size(dc_req_size),
    .dc_req_cmd(dc_req_cmd), .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .lq_resp_valid(lq_resp_valid), .lq_resp_data(lq_resp_data), .lq_resp_tag(lq_resp_tag),
    .flush_i(flush_i), .busy_o(busy_o),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_fail;
  logic [LQ_TAG_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // inputs change 1 time unit after the rising edge; outputs sampled at negedge
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    sq_req_valid     = 1'b0;
    sq_req_addr      = '0;
    sq_req_size      = '0;
    sq_store_data    = '0;
    sq_free_num_slot = FREE_W'(50);
    lq_req_valid     = 1'b0;
    lq_req_addr      = '0;
    lq_req_size      = '0;
    lq_req_tag       = '0;
    dc_req_ready     = 1'b0;
    dc_resp_valid    = 1'b0;
    dc_resp_data     = '0;
    flush_i          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic              sq_v;
    logic              lq_v;
    logic              flush;
    logic [FREE_W-1:0] free;
    logic              exp_sq_acc;
    logic              exp_lq_acc;
  } vec_t;

  vec_t vecs[10];

  // ---------------- reference model state ----------------
  bit                  m_busy;
  bit                  m_issued;
  bit                  m_store;
  bit                  m_kill;
  int                  m_starve;
  logic [ADDR_W-1:0]   m_addr;
  logic [SIZE_W-1:0]   m_size;
  logic [DATA_W-1:0]   m_data;
  logic [LQ_TAG_W-1:0] m_tag;

  initial begin
    int gq[$];
    bit seen_store;
    bit chk_next;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    clear_inputs();

    vecs[0] = '{1'b1, 1'b0, 1'b0, FREE_W'(50), 1'b1, 1'b0}; // store alone
    vecs[1] = '{1'b0, 1'b1, 1'b0, FREE_W'(50), 1'b0, 1'b1}; // load alone
    vecs[2] = '{1'b1, 1'b1, 1'b0, FREE_W'(50), 1'b0, 1'b1}; // both, plenty of room
    vecs[3] = '{1'b1, 1'b1, 1'b0, FREE_W'(2),  1'b1, 1'b0}; // at low water
    vecs[4] = '{1'b1, 1'b1, 1'b0, FREE_W'(3),  1'b0, 1'b1}; // just above low water
    vecs[5] = '{1'b1, 1'b1, 1'b0, FREE_W'(0),  1'b1, 1'b0}; // SQ full
    vecs[6] = '{1'b1, 1'b1, 1'b1, FREE_W'(50), 1'b1, 1'b0}; // flush favours store
    vecs[7] = '{1'b0, 1'b1, 1'b1, FREE_W'(50), 1'b0, 1'b0}; // flushed load only
    vecs[8] = '{1'b0, 1'b0, 1'b0, FREE_W'(50), 1'b0, 1'b0}; // nothing
    vecs[9] = '{1'b1, 1'b0, 1'b1, FREE_W'(1),  1'b1, 1'b0}; // store with flush

    // reset state
    next_cycle();
    @(negedge clock);
    check("rst_dc_valid", 64'(dc_req_valid), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_lq_resp_valid", 64'(lq_resp_valid), 64'(0));
    check("rst_cmd", 64'(dc_req_cmd), 64'(CMD_NONE));
    next_cycle();
    reset = 1'b0;

    // ---- table-driven arbitration from a fresh IDLE ----
    for (int i = 0; i < 10; i++) begin
      do_reset();
      sq_req_valid     = vecs[i].sq_v;
      lq_req_valid     = vecs[i].lq_v;
      flush_i          = vecs[i].flush;
      sq_free_num_slot = vecs[i].free;
      sq_req_addr      = ADDR_W'(32'h1000 + i);
      lq_req_addr      = ADDR_W'(32'h2000 + i);
      @(negedge clock);
      check($sformatf("vec%0d_sq_accept", i), 64'(sq_req_accept), 64'(vecs[i].exp_sq_acc));
      check($sformatf("vec%0d_lq_accept", i), 64'(lq_req_accept), 64'(vecs[i].exp_lq_acc));
      next_cycle();
      clear_inputs();
      @(negedge clock);
      check($sformatf("vec%0d_dc_valid", i), 64'(dc_req_valid),
            64'(vecs[i].exp_sq_acc | vecs[i].exp_lq_acc));
      check($sformatf("vec%0d_dc_cmd", i), 64'(dc_req_cmd),
            64'(vecs[i].exp_sq_acc ? CMD_STORE : (vecs[i].exp_lq_acc ? CMD_LOAD : CMD_NONE)));
    end

    // ---- store alone: accept, issue, back to idle ----
    do_reset();
    sq_req_valid  = 1'b1;
    sq_req_addr   = ADDR_W'(32'h100);
    sq_store_data = DATA_W'(64'hDEAD);
    sq_req_size   = 2'd3;
    dc_req_ready  = 1'b1;
    @(negedge clock);
    check("st_sq_accept_c0", 64'(sq_req_accept), 64'(1));
    check("st_lq_accept_c0", 64'(lq_req_accept), 64'(0));
    next_cycle();
    sq_req_valid = 1'b0;
    @(negedge clock);
    check("st_dc_valid_c1", 64'(dc_req_valid), 64'(1));
    check("st_dc_cmd_c1", 64'(dc_req_cmd), 64'(CMD_STORE));
    check("st_dc_addr_c1", 64'(dc_req_addr), 64'h100);
    check("st_dc_data_c1", 64'(dc_req_data), 64'hDEAD);
    check("st_dc_size_c1", 64'(dc_req_size), 64'(3));
    check("st_sq_accept_c1", 64'(sq_req_accept), 64'(0));
    next_cycle();
    @(negedge clock);
    check("st_busy_c2", 64'(busy_o), 64'(0));
    check("st_dc_valid_c2", 64'(dc_req_valid), 64'(0));
    check("st_dc_addr_c2", 64'(dc_req_addr), 64'(0));

    // ---- load with backpressure, then response ----
    do_reset();
    lq_req_valid = 1'b1;
    lq_req_tag   = 4'd3;
    lq_req_addr  = ADDR_W'(32'h200);
    lq_req_size  = 2'd2;
    @(negedge clock);
    check("ld_lq_accept", 64'(lq_req_accept), 64'(1));
    next_cycle();
    lq_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dc_req_ready = (k == 3);
      @(negedge clock);
      check($sformatf("ld_hold%0d_valid", k), 64'(dc_req_valid), 64'(1));
      check($sformatf("ld_hold%0d_addr", k), 64'(dc_req_addr), 64'h200);
      check($sformatf("ld_hold%0d_cmd", k), 64'(dc_req_cmd), 64'(CMD_LOAD));
      check($sformatf("ld_hold%0d_data", k), 64'(dc_req_data), 64'(0));
      check($sformatf("ld_hold%0d_size", k), 64'(dc_req_size), 64'(2));
      next_cycle();
    end
    dc_req_ready = 1'b0;
    @(negedge clock);
    check("ld_wait_busy", 64'(busy_o), 64'(1));
    check("ld_wait_dc_valid", 64'(dc_req_valid), 64'(0));
    next_cycle();
    dc_resp_valid = 1'b1;
    dc_resp_data  = DATA_W'(64'h55);
    @(negedge clock);
    check("ld_resp_not_early", 64'(lq_resp_valid), 64'(0));
    next_cycle();
    dc_resp_valid = 1'b0;
    dc_resp_data  = '0;
    @(negedge clock);
    check("ld_resp_valid", 64'(lq_resp_valid), 64'(1));
    check("ld_resp_tag", 64'(lq_resp_tag), 64'(3));
    check("ld_resp_data", 64'(lq_resp_data), 64'h55);
    check("ld_busy_after", 64'(busy_o), 64'(0));
    next_cycle();
    @(negedge clock);
    check("ld_resp_one_cycle", 64'(lq_resp_valid), 64'(0));

    // ---- starvation: four loads then one store, repeating ----
    do_reset();
    sq_req_valid     = 1'b1;
    lq_req_valid     = 1'b1;
    sq_free_num_slot = FREE_W'(50);
    dc_req_ready     = 1'b1;
    dc_resp_valid    = 1'b1;
    seen_store       = 1'b0;
    chk_next         = 1'b0;
    for (int c = 0; c < 80 && gq.size() < 10; c++) begin
      @(negedge clock);
      if (chk_next) begin
        check("starve_cleared", 64'(dbg_starve_cnt), 64'(0));
        chk_next = 1'b0;
      end
      if (sq_req_accept) begin
        gq.push_back(1);
        if (!seen_store) begin
          check("starve_at_limit", 64'(dbg_starve_cnt), 64'(STARVE_LIMIT));
          seen_store = 1'b1;
          chk_next   = 1'b1;
        end
      end else if (lq_req_accept) begin
        gq.push_back(0);
      end
      next_cycle();
    end
    check("starve_grant_count", 64'(gq.size() >= 10), 64'(1));
    for (int i = 0; i < 10 && i < gq.size(); i++) begin
      check($sformatf("starve_grant%0d", i), 64'(gq[i]), 64'((i % 5) == 4));
    end

    // ---- flush while waiting for load data ----
    do_reset();
    lq_req_valid = 1'b1;
    lq_req_tag   = 4'd5;
    lq_req_addr  = ADDR_W'(32'h300);
    dc_req_ready = 1'b1;
    @(negedge clock);
    check("fl_lq_accept", 64'(lq_req_accept), 64'(1));
    next_cycle();
    lq_req_valid = 1'b0;
    @(negedge clock);
    check("fl_issue_valid", 64'(dc_req_valid), 64'(1));
    next_cycle();
    flush_i = 1'b1;
    @(negedge clock);
    check("fl_wait_busy", 64'(busy_o), 64'(1));
    next_cycle();
    flush_i       = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_data  = DATA_W'(64'h77);
    @(negedge clock);
    check("fl_no_resp_a", 64'(lq_resp_valid), 64'(0));
    next_cycle();
    dc_resp_valid = 1'b0;
    sq_req_valid  = 1'b1;
    sq_req_addr   = ADDR_W'(32'h400);
    sq_store_data = DATA_W'(64'hBEEF);
    @(negedge clock);
    check("fl_no_resp_b", 64'(lq_resp_valid), 64'(0));
    check("fl_idle", 64'(busy_o), 64'(0));
    check("fl_store_accept", 64'(sq_req_accept), 64'(1));
    next_cycle();
    sq_req_valid = 1'b0;
    @(negedge clock);
    check("fl_store_cmd", 64'(dc_req_cmd), 64'(CMD_STORE));
    check("fl_store_addr", 64'(dc_req_addr), 64'h400);
    check("fl_no_resp_c", 64'(lq_resp_valid), 64'(0));

    // ---- reset while a load is in ISSUE ----
    do_reset();
    sq_req_valid     = 1'b1;
    lq_req_valid     = 1'b1;
    lq_req_tag       = 4'd9;
    sq_free_num_slot = FREE_W'(50);
    @(negedge clock);
    check("rs_lq_accept", 64'(lq_req_accept), 64'(1));
    next_cycle();
    sq_req_valid = 1'b0;
    lq_req_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clock);
    check("rs_dc_valid_in_reset", 64'(dc_req_valid), 64'(0));
    check("rs_busy_in_reset", 64'(busy_o), 64'(0));
    check("rs_cmd_in_reset", 64'(dc_req_cmd), 64'(CMD_NONE));
    next_cycle();
    reset         = 1'b0;
    dc_req_ready  = 1'b1;
    dc_resp_valid = 1'b1;
    @(negedge clock);
    check("rs_dc_valid_after", 64'(dc_req_valid), 64'(0));
    check("rs_busy_after", 64'(busy_o), 64'(0));
    check("rs_starve_after", 64'(dbg_starve_cnt), 64'(0));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rs_no_resp%0d", k), 64'(lq_resp_valid), 64'(0));
      next_cycle();
      @(negedge clock);
    end
    next_cycle();

    // ---- randomized traffic against the transaction model ----
    do_reset();
    m_busy = 0; m_issued = 0; m_store = 0; m_kill = 0; m_starve = 0;
    m_addr = '0; m_size = '0; m_data = '0; m_tag = '0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      bit want_store;
      bit want_load;
      bit e_sq;
      bit e_lq;
      bit e_dcv;
      reset            = ($urandom_range(0, 199) == 0);
      sq_req_valid     = ($urandom_range(0, 99) < 55);
      lq_req_valid     = ($urandom_range(0, 99) < 65);
      flush_i          = ($urandom_range(0, 99) < 10);
      sq_free_num_slot = ($urandom_range(0, 3) == 0) ? FREE_W'($urandom_range(0, 128))
                                                     : FREE_W'($urandom_range(0, 6));
      sq_req_addr      = $urandom();
      sq_req_size      = SIZE_W'($urandom_range(0, 3));
      sq_store_data    = {$urandom(), $urandom()};
      lq_req_addr      = $urandom();
      lq_req_size      = SIZE_W'($urandom_range(0, 3));
      lq_req_tag       = LQ_TAG_W'($urandom_range(0, 15));
      dc_req_ready     = ($urandom_range(0, 99) < 50);
      dc_resp_valid    = ($urandom_range(0, 99) < 40);
      dc_resp_data     = {$urandom(), $urandom()};
      @(negedge clock);
      if (reset) begin
        check("rnd_rst_sq_accept", 64'(sq_req_accept), 64'(0));
        check("rnd_rst_lq_accept", 64'(lq_req_accept), 64'(0));
        check("rnd_rst_dc_valid", 64'(dc_req_valid), 64'(0));
        check("rnd_rst_dc_cmd", 64'(dc_req_cmd), 64'(CMD_NONE));
        check("rnd_rst_busy", 64'(busy_o), 64'(0));
        check("rnd_rst_lq_resp", 64'(lq_resp_valid), 64'(0));
        m_busy = 0; m_issued = 0; m_kill = 0; m_starve = 0;
        exp_q.delete();
      end else begin
        want_store = sq_req_valid && (!lq_req_valid || flush_i ||
                     (int'(sq_free_num_slot) <= SQ_LOW_WATER) || (m_starve >= STARVE_LIMIT));
        want_load  = !want_store && lq_req_valid && !flush_i;
        e_sq  = !m_busy && want_store;
        e_lq  = !m_busy && want_load;
        e_dcv = m_busy && !m_issued;
        check("rnd_sq_accept", 64'(sq_req_accept), 64'(e_sq));
        check("rnd_lq_accept", 64'(lq_req_accept), 64'(e_lq));
        check("rnd_dc_valid", 64'(dc_req_valid), 64'(e_dcv));
        check("rnd_dc_addr", 64'(dc_req_addr), e_dcv ? 64'(m_addr) : 64'(0));
        check("rnd_dc_size", 64'(dc_req_size), e_dcv ? 64'(m_size) : 64'(0));
        check("rnd_dc_cmd", 64'(dc_req_cmd),
              e_dcv ? 64'(m_store ? CMD_STORE : CMD_LOAD) : 64'(CMD_NONE));
        check("rnd_dc_data", 64'(dc_req_data), (e_dcv && m_store) ? 64'(m_data) : 64'(0));
        check("rnd_busy", 64'(busy_o), 64'(m_busy));
        check("rnd_starve", 64'(dbg_starve_cnt), 64'(m_starve));
        check("rnd_lq_resp_valid", 64'(lq_resp_valid), 64'(exp_q.size() != 0));
        if (lq_resp_valid && exp_q.size() != 0) begin
          logic [LQ_TAG_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          check("rnd_lq_resp_data", 64'(lq_resp_data), 64'(e[DATA_W-1:0]));
          check("rnd_lq_resp_tag", 64'(lq_resp_tag), 64'(e[DATA_W +: LQ_TAG_W]));
        end else if (exp_q.size() != 0) begin
          exp_q.delete();
        end
        // advance the model by one cycle
        if (e_sq || e_lq) begin
          m_busy   = 1;
          m_issued = 0;
          m_store  = e_sq;
          m_kill   = 0;
          if (e_sq) begin
            m_addr   = sq_req_addr;
            m_size   = sq_req_size;
            m_data   = sq_store_data;
            m_tag    = '0;
            m_starve = 0;
          end else begin
            m_addr = lq_req_addr;
            m_size = lq_req_size;
            m_data = '0;
            m_tag  = lq_req_tag;
            if (sq_req_valid && m_starve < STARVE_LIMIT) m_starve++;
          end
        end else if (m_busy) begin
          if (!m_store && flush_i) m_kill = 1;
          if (!m_issued) begin
            if (dc_req_ready) begin
              if (m_store) m_busy = 0;
              else m_issued = 1;
            end
          end else if (dc_resp_valid) begin
            if (!m_kill) exp_q.push_back({m_tag, dc_resp_data});
            m_busy = 0;
          end
        end
      end
      next_cycle();
    end
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    check("rnd_final_resp_valid", 64'(lq_resp_valid), 64'(exp_q.size() != 0));

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter SQ_SIZE, default 128, store queue depth used for the free-slot width.
REQ-002 SHALL have parameter SQ_LOW_WATER, default 2, free-slot threshold forcing store priority.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive load grants after which a waiting store wins.
REQ-004 SHALL have parameter LQ_TAG_W, default 4, width of the load tag.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-006 SHALL have these store-side ports:
- sq_req_valid in 1, store at SQ head is committed and ready.
- sq_req_addr in ADDR, store address.
- sq_req_size in MEM_SIZE, store size.
- sq_store_data in MEM_BLOCK, store data.
- sq_free_num_slot in $clog2(SQ_SIZE+1), SQ free slots.
- sq_req_accept out 1, store taken; SQ pops its head.
REQ-007 SHALL have these load-side ports:
- lq_req_valid in 1, load request.
- lq_req_addr in ADDR, load address.
- lq_req_size in MEM_SIZE, load size.
- lq_req_tag in LQ_TAG_W, load tag.
- lq_req_accept out 1, load taken.
REQ-008 SHALL have these D$ request ports:
- dc_req_valid out 1, request to D$.
- dc_req_addr out ADDR, request address.
- dc_req_size out MEM_SIZE, request size.
- dc_req_cmd out MEM_COMMAND, MEM_LOAD or MEM_STORE.
- dc_req_data out MEM_BLOCK, store data; 0 for loads.
- dc_req_ready in 1, D$ takes the request this cycle.
REQ-009 SHALL have these response and control ports:
- dc_resp_valid in 1, load data returned from D$.
- dc_resp_data in MEM_BLOCK, load data.
- lq_resp_valid out 1, load completion pulse.
- lq_resp_data out MEM_BLOCK, load data.
- lq_resp_tag out LQ_TAG_W, completing load tag.
- flush_i in 1, mispredict squash of speculative loads.
- busy_o out 1, state != IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE and WAIT_RESP.
REQ-011 IDLE: grant occurs when sq_req_valid, or lq_req_valid with flush_i low; the winner's accept is asserted combinationally that cycle, the request is latched into an internal register, and the state goes to ISSUE.
REQ-012 SHALL grant the store if sq_req_valid and any of: lq_req_valid low; flush_i high; sq_free_num_slot <= SQ_LOW_WATER; starve_cnt >= STARVE_LIMIT. Otherwise SHALL grant the load.
REQ-013 SHALL never assert both accepts in one cycle, and SHALL never assert any accept outside IDLE.
REQ-014 starve_cnt:
- increments (saturating at STARVE_LIMIT) on each load grant while sq_req_valid is high;
- clears on each store grant;
- otherwise holds.
REQ-015 ISSUE: dc_req_valid=1 and all dc_req_* fields are driven from the latched register and held stable until dc_req_ready.
REQ-016 ISSUE on dc_req_ready: a store goes to IDLE; a load goes to WAIT_RESP. Minimum store occupancy is therefore 2 cycles (IDLE grant, ISSUE).
REQ-017 WAIT_RESP on dc_resp_valid: go to IDLE next cycle; if the kill flag is clear, assert lq_resp_valid for exactly one cycle (registered, the cycle after dc_resp_valid) with lq_resp_data=dc_resp_data and lq_resp_tag=the latched tag.
REQ-018 SHALL ignore dc_resp_valid outside WAIT_RESP.
REQ-019 Flush:
- flush_i in ISSUE or WAIT_RESP with a latched load sets the kill flag; the request still completes its D$ handshake and response, but lq_resp_valid is suppressed.
- Kill clears on return to IDLE.
- Stores are never killed.
REQ-020 A flush_i and dc_resp_valid in the same WAIT_RESP cycle SHALL suppress the response.
REQ-021 dc_req_cmd SHALL be MEM_STORE for a latched store, MEM_LOAD otherwise; dc_req_data SHALL be 0 for loads.
REQ-022 Outside ISSUE, dc_req_valid SHALL be 0 and all dc_req_* fields SHALL be 0.
REQ-023 busy_o SHALL be 1 in ISSUE and WAIT_RESP.

Reset
REQ-024 reset SHALL force IDLE and clear starve_cnt, the kill flag and all latched request fields.
REQ-025 While reset is high, all outputs SHALL be 0 (dc_req_cmd is the 0 encoding); an in-flight request is abandoned and no lq_resp_valid follows.
REQ-026 The first grant MAY occur in the first cycle after reset deasserts.

Verification
REQ-027 Store alone, sq_req_addr=0x100, data=0xDEAD, dc_req_ready=1 -> sq_req_accept at cycle 0; dc_req_valid with MEM_STORE, 0x100, 0xDEAD at cycle 1; IDLE at cycle 2.
REQ-028 Load tag=3 with dc_req_ready held low 3 cycles -> dc_req_* stable for 4 cycles; dc_resp_valid with data 0x55 two cycles later -> lq_resp_valid one cycle later, tag=3, data=0x55.
REQ-029 Both requesters continuously valid, sq_free_num_slot=50, STARVE_LIMIT=4 -> 4 load grants, then 1 store grant; the pattern repeats; starve_cnt returns to 0.
REQ-030 Both requesters valid with sq_free_num_slot=2 -> store granted; lq_req_accept=0.
REQ-031 Load in WAIT_RESP, flush_i pulsed, then dc_resp_valid -> no lq_resp_valid; FSM returns to IDLE; the next store is granted normally.
REQ-032 reset asserted during ISSUE -> next cycle: dc_req_valid=0, busy_o=0, starve_cnt=0; no response is ever emitted.
